// File: rtl/ivector_drv_pkg.sv
// Shared types and payload helpers for the IVector request/indication driver.
package ivector_drv_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_DATA    = 2'd1,
        ERR_METH    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_e;

    localparam int IV_LANES  = 10;
    localparam int IV_DATA_W = 32;
    localparam int LANE_W    = $clog2(IV_LANES);
    localparam int SEQ_W     = IV_DATA_W - 8;

    function automatic logic [IV_DATA_W-1:0] pack_payload(input logic [7:0] lane,
                                                          input logic [SEQ_W-1:0] seq);
        return {lane, seq};
    endfunction

    function automatic logic [7:0] payload_lane(input logic [IV_DATA_W-1:0] v);
        return v[IV_DATA_W-1 -: 8];
    endfunction

    function automatic logic [SEQ_W-1:0] payload_seq(input logic [IV_DATA_W-1:0] v);
        return v[SEQ_W-1:0];
    endfunction

endpackage

// File: rtl/ivector_lane_track.sv
// Per-lane bookkeeping: credits, requests remaining, and tx/rx sequence numbers.
module ivector_lane_track
    import ivector_drv_pkg::*;
#(
    parameter int LANE_ID = 0,
    parameter int DATA_W  = IV_DATA_W,
    parameter int CREDITS = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              issue_fire_i,
    input  logic              heard_fire_i,
    output logic              eligible_o,
    output logic              idle_o,
    output logic              issue_done_o,
    output logic [DATA_W-1:0] tx_payload_o,
    output logic [DATA_W-1:0] exp_payload_o
);

    localparam int LSEQ_W = DATA_W - 8;
    localparam int CR_W   = $clog2(CREDITS + 1);
    localparam logic [CR_W-1:0] CR_FULL  = CR_W'(CREDITS);
    localparam logic [7:0]      LANE_TAG = 8'(LANE_ID);

    logic [CR_W-1:0]   credit_q, credit_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [LSEQ_W-1:0] tx_seq_q, tx_seq_d;
    logic [LSEQ_W-1:0] rx_seq_q, rx_seq_d;

    always_comb begin
        credit_d    = credit_q;
        remaining_d = remaining_q;
        tx_seq_d    = tx_seq_q;
        rx_seq_d    = rx_seq_q;
        if (load_i) begin
            credit_d    = CR_FULL;
            remaining_d = count_i;
            tx_seq_d    = '0;
            rx_seq_d    = '0;
        end else begin
            if (issue_fire_i) begin
                remaining_d = remaining_q - CNT_W'(1);
                tx_seq_d    = tx_seq_q + LSEQ_W'(1);
            end
            if (heard_fire_i) rx_seq_d = rx_seq_q + LSEQ_W'(1);
            // A say and a heard in the same cycle cancel out on the credit count.
            case ({issue_fire_i, heard_fire_i})
                2'b10:   credit_d = credit_q - CR_W'(1);
                2'b01:   credit_d = credit_q + CR_W'(1);
                default: credit_d = credit_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q    <= CR_FULL;
            remaining_q <= '0;
            tx_seq_q    <= '0;
            rx_seq_q    <= '0;
        end else begin
            credit_q    <= credit_d;
            remaining_q <= remaining_d;
            tx_seq_q    <= tx_seq_d;
            rx_seq_q    <= rx_seq_d;
        end
    end

    assign eligible_o    = (remaining_q != '0) && (credit_q != '0);
    assign idle_o        = (credit_q == CR_FULL);
    assign issue_done_o  = (remaining_q == '0);
    assign tx_payload_o  = {LANE_TAG, tx_seq_q};
    assign exp_payload_o = {LANE_TAG, rx_seq_q};

endmodule

// File: rtl/ivector_driver.sv
// IVector initiator/checker: round-robin say issue under per-lane credits,
// in-order heard checking, drain with timeout, sticky first-error report.
module ivector_driver
    import ivector_drv_pkg::*;
#(
    parameter int LANES   = IV_LANES,
    parameter int DATA_W  = IV_DATA_W,
    parameter int CREDITS = 2,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic [CNT_W-1:0]         count,
    output logic                     say__ENA,
    output logic [$clog2(LANES)-1:0] say_meth,
    output logic [DATA_W-1:0]        say_v,
    input  logic                     say__RDY,
    input  logic                     heard__ENA,
    input  logic [$clog2(LANES)-1:0] heard_meth,
    input  logic [DATA_W-1:0]        heard_v,
    output logic                     heard__RDY,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [7:0]               err_lane,
    output logic [1:0]               err_code,
    output logic [31:0]              issued_total,
    output logic [31:0]              heard_total
);

    localparam int LW    = $clog2(LANES);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [LW-1:0]     ptr_q, ptr_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       issued_q, issued_d, heard_q, heard_d;
    logic              error_q, error_d;
    logic [7:0]        err_lane_q, err_lane_d;
    err_e              err_code_q, err_code_d;

    logic [LANES-1:0]  eligible, idle, issue_done, issue_fire, heard_fire;
    logic [DATA_W-1:0] tx_payload  [LANES];
    logic [DATA_W-1:0] exp_payload [LANES];
    logic [DATA_W-1:0] sel_tx, sel_exp;
    logic              sel_elig, sel_full, meth_ok, heard_any, heard_ok;
    logic              bad_meth, data_bad, tmo_hit, load;
    logic [7:0]        tmo_lane;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ivector_lane_track #(
            .LANE_ID (g),
            .DATA_W  (DATA_W),
            .CREDITS (CREDITS),
            .CNT_W   (CNT_W)
        ) u_track (
            .clk_i         (CLK),
            .rst_i         (RST),
            .load_i        (load),
            .count_i       (count),
            .issue_fire_i  (issue_fire[g]),
            .heard_fire_i  (heard_fire[g]),
            .eligible_o    (eligible[g]),
            .idle_o        (idle[g]),
            .issue_done_o  (issue_done[g]),
            .tx_payload_o  (tx_payload[g]),
            .exp_payload_o (exp_payload[g])
        );
    end

    // Lane selection for the issue pointer and the incoming heard.
    always_comb begin
        sel_tx     = '0;
        sel_elig   = 1'b0;
        sel_exp    = '0;
        sel_full   = 1'b0;
        issue_fire = '0;
        heard_fire = '0;
        tmo_lane   = '0;
        for (int l = 0; l < LANES; l++) begin
            if (ptr_q == LW'(l)) begin
                sel_tx   = tx_payload[l];
                sel_elig = eligible[l];
            end
            if (heard_meth == LW'(l)) begin
                sel_exp  = exp_payload[l];
                sel_full = idle[l];
            end
            issue_fire[l] = say__ENA && (ptr_q == LW'(l));
            heard_fire[l] = heard_ok && (heard_meth == LW'(l));
        end
        for (int l = LANES - 1; l >= 0; l--) begin
            if (!idle[l]) tmo_lane = 8'(l);
        end
    end

    assign meth_ok   = ({1'b0, heard_meth} < (LW + 1)'(LANES));
    assign heard_any = heard__ENA && heard__RDY;
    assign heard_ok  = heard_any && meth_ok && !sel_full;
    assign bad_meth  = heard_any && !(meth_ok && !sel_full);
    assign data_bad  = heard_ok && (heard_v != sel_exp);
    assign tmo_hit   = (state_q == DRAIN) && !heard_any && !(&idle)
                    && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign load      = start && ((state_q == IDLE) || (state_q == DONE));

    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = ISSUE;
            ISSUE:      if (&issue_done) state_d = DRAIN;
            DRAIN:      if ((&idle) || tmo_hit) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ISSUE) || (state_q == DRAIN);
        done       = (state_q == DONE);
        heard__RDY = busy;
        say__ENA   = (state_q == ISSUE) && sel_elig && say__RDY;
    end

    always_comb begin
        ptr_d      = ptr_q;
        tmo_d      = tmo_q;
        issued_d   = issued_q;
        heard_d    = heard_q;
        error_d    = error_q;
        err_lane_d = err_lane_q;
        err_code_d = err_code_q;
        if (load) begin
            ptr_d      = '0;
            tmo_d      = '0;
            issued_d   = '0;
            heard_d    = '0;
            error_d    = 1'b0;
            err_lane_d = '0;
            err_code_d = ERR_NONE;
        end else begin
            if (state_q == ISSUE) ptr_d = (ptr_q == LW'(LANES - 1)) ? '0 : ptr_q + LW'(1);
            if (say__ENA)  issued_d = issued_q + 32'd1;
            if (heard_any) heard_d  = heard_q + 32'd1;
            if ((state_q != DRAIN) || heard_any) tmo_d = '0;
            else                                 tmo_d = tmo_q + TMO_W'(1);
            // Only the first error is recorded; later ones are still detected but dropped.
            if (!error_q && (bad_meth || data_bad || tmo_hit)) begin
                error_d = 1'b1;
                if (bad_meth) begin
                    err_lane_d = 8'(heard_meth);
                    err_code_d = ERR_METH;
                end else if (data_bad) begin
                    err_lane_d = 8'(heard_meth);
                    err_code_d = ERR_DATA;
                end else begin
                    err_lane_d = tmo_lane;
                    err_code_d = ERR_TIMEOUT;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q      <= '0;
            tmo_q      <= '0;
            issued_q   <= '0;
            heard_q    <= '0;
            error_q    <= 1'b0;
            err_lane_q <= '0;
            err_code_q <= ERR_NONE;
        end else begin
            ptr_q      <= ptr_d;
            tmo_q      <= tmo_d;
            issued_q   <= issued_d;
            heard_q    <= heard_d;
            error_q    <= error_d;
            err_lane_q <= err_lane_d;
            err_code_q <= err_code_d;
        end
    end

    assign say_meth     = ptr_q;
    assign say_v        = sel_tx;
    assign error        = error_q;
    assign err_lane     = err_lane_q;
    assign err_code     = err_code_q;
    assign issued_total = issued_q;
    assign heard_total  = heard_q;

endmodule

// File: tb/tb_ivector_driver.sv
// Bench for ivector_driver: looped-back lane FIFO target with scoreboarded say payloads.
module tb_ivector_driver;
    import ivector_drv_pkg::*;

    localparam int LANES   = 10;
    localparam int DATA_W  = 32;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1024;
    localparam int LW      = $clog2(LANES);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  count = '0;
    logic              say_ena;
    logic [LW-1:0]     say_meth;
    logic [DATA_W-1:0] say_v;
    logic              say_rdy = 1'b0;
    logic              heard_ena = 1'b0;
    logic [LW-1:0]     heard_meth = '0;
    logic [DATA_W-1:0] heard_v = '0;
    logic              heard_rdy, busy, done, error;
    logic [7:0]        err_lane;
    logic [1:0]        err_code;
    logic [31:0]       issued_total, heard_total;

    int n_chk = 0;
    int n_pass = 0;

    logic [DATA_W-1:0] exp_q  [LANES][$];
    logic [DATA_W-1:0] fifo_q [LANES][$];
    int  iss_cnt [LANES];
    int  run_count = 0;
    bit  hold_heard = 0, blk_en = 0, corrupt_en = 0, drop_en = 0, inject_req = 0;

    ivector_driver #(
        .LANES(LANES), .DATA_W(DATA_W), .CREDITS(2), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk), .RST(rst), .start(start), .count(count),
        .say__ENA(say_ena), .say_meth(say_meth), .say_v(say_v), .say__RDY(say_rdy),
        .heard__ENA(heard_ena), .heard_meth(heard_meth), .heard_v(heard_v),
        .heard__RDY(heard_rdy), .busy(busy), .done(done), .error(error),
        .err_lane(err_lane), .err_code(err_code),
        .issued_total(issued_total), .heard_total(heard_total)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Target: per-lane FIFO (depth 2) looping says back as heards; also the say monitor.
    initial begin
        int hsel, off, l, lane;
        logic [DATA_W-1:0] v, e;
        logic [SEQ_W-1:0]  sq;
        forever begin
            @(negedge clk);
            heard_ena = 1'b0;
            hsel = -1;
            if (inject_req) begin
                heard_ena  = 1'b1;
                heard_meth = LW'(12);
                heard_v    = pack_payload(8'd12, '0);
            end else if (!hold_heard && $urandom_range(0, 9) < 6) begin
                off = $urandom_range(0, LANES - 1);
                for (int k = 0; k < LANES; k++) begin
                    l = (off + k) % LANES;
                    if (hsel < 0 && fifo_q[l].size() != 0) hsel = l;
                end
                if (hsel >= 0) begin
                    heard_ena  = 1'b1;
                    heard_meth = LW'(hsel);
                    heard_v    = fifo_q[hsel][0];
                end
            end
            say_rdy = (int'(say_meth) < LANES) && (fifo_q[say_meth].size() < 2)
                   && !(blk_en && say_meth == LW'(4)) && ($urandom_range(0, 3) != 0);
            #1;
            if (!rst) begin
                if (say_ena) begin
                    lane = int'(say_meth);
                    check("say_pending", exp_q[lane].size() != 0, 1);
                    if (exp_q[lane].size() != 0) begin
                        e = exp_q[lane].pop_front();
                        check("say_payload", say_v, e);
                    end
                    iss_cnt[lane]++;
                    sq = payload_seq(say_v);
                    if (!(drop_en && lane == 2 && sq == SEQ_W'(run_count - 1))) begin
                        v = say_v;
                        if (corrupt_en && lane == 7 && sq == SEQ_W'(1)) v[0] = ~v[0];
                        fifo_q[lane].push_back(v);
                    end
                end
                if (heard_ena && heard_rdy) begin
                    if (inject_req) inject_req = 0;
                    else if (hsel >= 0) void'(fifo_q[hsel].pop_front());
                end
            end
        end
    end

    task automatic start_run(input int c);
        for (int l = 0; l < LANES; l++) begin
            iss_cnt[l] = 0;
            for (int s = 0; s < c; s++) exp_q[l].push_back(pack_payload(8'(l), SEQ_W'(s)));
        end
        run_count = c;
        count = CNT_W'(c);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(posedge clk); #2;
            cyc++;
        end
        check(name, done, 1);
    endtask

    task automatic check_drained(input string name);
        int tot = 0;
        for (int l = 0; l < LANES; l++) tot += exp_q[l].size();
        check(name, tot, 0);
    endtask

    task automatic flush_model();
        for (int l = 0; l < LANES; l++) begin
            exp_q[l].delete();
            fifo_q[l].delete();
        end
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_say_ena", say_ena, 0);
        check("rst_heard_rdy", heard_rdy, 0);
        check("rst_totals", {issued_total, heard_total}, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        start_run(3);
        check("lb_busy", busy, 1);
        wait_done("lb_done", 3000, cyc);
        check("lb_issued", issued_total, 30);
        check("lb_heard", heard_total, 30);
        check("lb_error", error, 0);
        check_drained("lb_sb_drained");

        blk_en = 1;
        start_run(2);
        repeat (50) @(posedge clk);
        #2;
        check("bp_lane4_held", iss_cnt[4], 0);
        check("bp_busy", busy, 1);
        blk_en = 0;
        wait_done("bp_done", 3000, cyc);
        check("bp_lane4_issued", iss_cnt[4], 2);
        check("bp_issued", issued_total, 20);
        check("bp_error", error, 0);

        hold_heard = 1;
        start_run(5);
        repeat (100) @(posedge clk);
        #2;
        check("cl_issued_stall", issued_total, 20);
        check("cl_busy", busy, 1);
        check("cl_heard_none", heard_total, 0);
        hold_heard = 0;
        wait_done("cl_done", 4000, cyc);
        check("cl_issued", issued_total, 50);
        check("cl_heard", heard_total, 50);
        check("cl_error", error, 0);
        check_drained("cl_sb_drained");

        corrupt_en = 1;
        start_run(3);
        wait_done("cor_done", 3000, cyc);
        corrupt_en = 0;
        check("cor_error", error, 1);
        check("cor_lane", err_lane, 7);
        check("cor_code", err_code, 1);
        check("cor_issued", issued_total, 30);

        start_run(3);
        inject_req = 1;
        wait_done("bm_done", 800, cyc);
        check("bm_injected", inject_req, 0);
        check("bm_code", err_code, 2);
        check("bm_lane", err_lane, 12);
        check("bm_issued", issued_total, 30);
        check("bm_heard", heard_total, 31);

        drop_en = 1;
        start_run(3);
        wait_done("tmo_done", TIMEOUT + 1500, cyc);
        drop_en = 0;
        check("tmo_not_early", cyc > TIMEOUT, 1);
        check("tmo_error", error, 1);
        check("tmo_code", err_code, 3);
        check("tmo_issued", issued_total, 30);
        check("tmo_heard", heard_total, 29);

        start_run(5);
        repeat (8) @(posedge clk);
        #2;
        check("mid_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #2;
        check("rr_say_ena", say_ena, 0);
        check("rr_say_meth_v", {say_meth, say_v}, 0);
        check("rr_status", {heard_rdy, busy, done, error}, 0);
        check("rr_err", {err_lane, err_code}, 0);
        check("rr_totals", {issued_total, heard_total}, 0);
        rst = 1'b0;
        flush_model();
        @(posedge clk); #2;

        start_run(3);
        wait_done("re_done", 3000, cyc);
        check("re_issued", issued_total, 30);
        check("re_heard", heard_total, 30);
        check("re_error", error, 0);
        check_drained("re_sb_drained");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

endmodule
